// File: rtl/storage_sequencer.sv
// storage_sequencer
//   Frame sequencer for the echo storage FIFO. It flushes the FIFO and latches
//   the storage mode. It then captures exactly FRAME_LEN samples from the front
//   end, hands them to the host one word at a time, and returns to idle.
//
// Parameters
//   FRAME_LEN     samples written / words read per frame
//   CNT_W         width of the sample and word counters (2**CNT_W > FRAME_LEN)
//   FLUSH_CYCLES  cycles FIFO_RESET is held high during a flush (>= 1)
//
// Ports
//   CLK, RESET        clock, asynchronous active-high reset
//   MODE_REQ          requested storage mode (0 = oscilloscope, 1 = Doppler)
//   ARM, ABORT        one-cycle frame start / cancel requests
//   SAMPLE_VALID      one-cycle sample strobe from the front end
//   HOST_REQ          one-cycle host request for one word
//   FIFO_FULL/EMPTY   FIFO status flags
//   MODE              latched storage mode
//   FIFO_WRITE/READ   one-cycle FIFO strobes
//   FIFO_ENABLE       FIFO read/write enable (CAPTURE and DRAIN)
//   FIFO_RESET        FIFO flush
//   HOST_ACK          FIFO output word valid, two cycles after an accepted request
//   BUSY              not in IDLE
//   FRAME_DONE        one-cycle pulse after the last word of a frame
//   OVERRUN           sticky dropped-sample flag, cleared on RESET or flush entry
// All outputs are registered.
module storage_sequencer #(
    parameter int FRAME_LEN    = 1024,
    parameter int CNT_W        = 11,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic CLK,
    input  logic RESET,
    input  logic MODE_REQ,
    input  logic ARM,
    input  logic ABORT,
    input  logic SAMPLE_VALID,
    input  logic HOST_REQ,
    input  logic FIFO_FULL,
    input  logic FIFO_EMPTY,
    output logic MODE,
    output logic FIFO_WRITE,
    output logic FIFO_READ,
    output logic FIFO_ENABLE,
    output logic FIFO_RESET,
    output logic HOST_ACK,
    output logic BUSY,
    output logic FRAME_DONE,
    output logic OVERRUN
);

    localparam int FW = $clog2(FLUSH_CYCLES) + 1;
    localparam logic [FW-1:0]    FLUSH_LAST = FW'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FRAME_LEN);

    typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_CAPTURE, S_DRAIN, S_DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] rd_cnt;
    logic [FW-1:0]    flush_cnt;
    logic             arm_pend;     // flush was started by ARM: continue to CAPTURE

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= S_IDLE;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            flush_cnt   <= '0;
            arm_pend    <= 1'b0;
            MODE        <= 1'b0;
            FIFO_WRITE  <= 1'b0;
            FIFO_READ   <= 1'b0;
            FIFO_ENABLE <= 1'b0;
            FIFO_RESET  <= 1'b1;
            HOST_ACK    <= 1'b0;
            BUSY        <= 1'b0;
            FRAME_DONE  <= 1'b0;
            OVERRUN     <= 1'b0;
        end else begin
            // Strobes default low; this also cancels anything pending on ABORT.
            FIFO_WRITE <= 1'b0;
            FIFO_READ  <= 1'b0;
            HOST_ACK   <= 1'b0;
            FRAME_DONE <= 1'b0;

            case (state)
                S_IDLE: begin
                    FIFO_RESET  <= 1'b0;
                    FIFO_ENABLE <= 1'b0;
                    BUSY        <= 1'b0;
                    // ARM and a mode change together still produce one flush.
                    if (ARM || (MODE_REQ != MODE)) begin
                        state      <= S_FLUSH;
                        MODE       <= MODE_REQ;
                        OVERRUN    <= 1'b0;
                        wr_cnt     <= '0;
                        rd_cnt     <= '0;
                        flush_cnt  <= '0;
                        arm_pend   <= ARM;
                        FIFO_RESET <= 1'b1;
                        BUSY       <= 1'b1;
                    end
                end

                S_FLUSH: begin
                    if (ABORT) begin
                        state      <= S_IDLE;
                        FIFO_RESET <= 1'b0;
                        BUSY       <= 1'b0;
                    end else if (flush_cnt == FLUSH_LAST) begin
                        FIFO_RESET <= 1'b0;
                        if (arm_pend) begin
                            state       <= S_CAPTURE;
                            FIFO_ENABLE <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                            BUSY  <= 1'b0;
                        end
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end

                S_CAPTURE: begin
                    if (ABORT) begin
                        state       <= S_IDLE;
                        FIFO_ENABLE <= 1'b0;
                        BUSY        <= 1'b0;
                    end else if (SAMPLE_VALID) begin
                        // FIFO_WRITE high now means a sample was accepted last
                        // cycle; the strobe-clocked FIFO needs a low cycle between.
                        if (FIFO_FULL || FIFO_WRITE) begin
                            OVERRUN <= 1'b1;
                        end else begin
                            FIFO_WRITE <= 1'b1;
                            wr_cnt     <= wr_cnt + 1'b1;
                            if (wr_cnt == CNT_LAST)
                                state <= S_DRAIN;
                        end
                    end
                end

                S_DRAIN: begin
                    if (ABORT) begin
                        state       <= S_IDLE;
                        FIFO_ENABLE <= 1'b0;
                        BUSY        <= 1'b0;
                    end else begin
                        HOST_ACK <= FIFO_READ;
                        if (HOST_ACK && (rd_cnt == CNT_FULL)) begin
                            state       <= S_DONE;
                            FIFO_ENABLE <= 1'b0;
                            FRAME_DONE  <= 1'b1;
                        end else if (HOST_REQ && !FIFO_READ && !HOST_ACK &&
                                     !FIFO_EMPTY && (rd_cnt != CNT_FULL)) begin
                            // A read is in flight while READ or ACK is high.
                            FIFO_READ <= 1'b1;
                            rd_cnt    <= rd_cnt + 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                end

                default: begin
                    state       <= S_IDLE;
                    FIFO_ENABLE <= 1'b0;
                    BUSY        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/storage_sequencer.md
# storage_sequencer

Frame sequencer for the echo storage FIFO. It flushes the FIFO, selects the storage mode (oscilloscope or Doppler), and fills the FIFO with exactly FRAME_LEN samples from the acquisition front end. It then hands the frame to the host readout port one word at a time and returns to idle. It sits between the ADC/demodulator sample strobe, the host interface and the storage layer. It produces that layer's WRITE, READ, ENABLE, RESET and MODE controls.

## Interface
- FRAME_LEN, 1024: samples per frame written, and words per frame read.
- CNT_W, 11: sample and word counter width. Must satisfy 2^CNT_W > FRAME_LEN.
- FLUSH_CYCLES, 4: number of cycles FIFO_RESET is held high during a flush (≥1).
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- MODE_REQ  in  1  requested storage mode: 0 = oscilloscope, 1 = Doppler.
- ARM  in  1  one-cycle request to acquire one frame.
- ABORT  in  1  one-cycle request to cancel the current frame.
- SAMPLE_VALID  in  1  one-cycle sample strobe from the front end.
- HOST_REQ  in  1  one-cycle request from the host for one word.
- FIFO_FULL  in  1  FIFO full flag.
- FIFO_EMPTY  in  1  FIFO empty flag.
- MODE  out  1  latched storage mode driven to the storage layer.
- FIFO_WRITE  out  1  write strobe, high for one cycle per sample.
- FIFO_READ  out  1  read strobe, high for one cycle per word.
- FIFO_ENABLE  out  1  FIFO read and write enable.
- FIFO_RESET  out  1  FIFO flush.
- HOST_ACK  out  1  one-cycle pulse: the FIFO output word is valid.
- BUSY  out  1  high in any state other than IDLE.
- FRAME_DONE  out  1  one-cycle pulse when a frame has been fully read.
- OVERRUN  out  1  sticky error flag; cleared only by RESET or by entering FLUSH.

## Operation
- States: IDLE, FLUSH, CAPTURE, DRAIN, DONE.
- IDLE:
  - FIFO_ENABLE = 0.
  - ARM, or MODE_REQ ≠ MODE, moves to FLUSH.
  - ARM and a mode change in the same cycle cause a single flush.
  - A flush caused only by a mode change returns to IDLE; a flush caused by ARM continues to CAPTURE.
- FLUSH:
  - On entry: MODE ← MODE_REQ, OVERRUN ← 0, both counters ← 0.
  - FIFO_RESET is held high for FLUSH_CYCLES cycles, then the state moves on.
  - MODE changes only when FLUSH is entered.
- CAPTURE:
  - FIFO_ENABLE = 1.
  - A SAMPLE_VALID accepted while FIFO_FULL = 0 causes FIFO_WRITE high on the next cycle and increments the write count.
  - A SAMPLE_VALID is dropped and OVERRUN is set when either:
    - FIFO_FULL = 1, or
    - it arrives in the cycle immediately after an accepted sample. The FIFO is clocked by the strobe, so consecutive write pulses must be separated by a low cycle.
  - When the write count reaches FRAME_LEN, the state moves to DRAIN. Further SAMPLE_VALID pulses are ignored without setting OVERRUN.
- DRAIN:
  - FIFO_ENABLE = 1.
  - A HOST_REQ with no read in flight and FIFO_EMPTY = 0 gives FIFO_READ high at t+1 and HOST_ACK high at t+2, and increments the read count.
  - A HOST_REQ is ignored when a read is in flight (from the accepted request through its ACK cycle) or when FIFO_EMPTY = 1. The host must re-request.
  - After the HOST_ACK for word FRAME_LEN, the state moves to DONE.
- DONE: FRAME_DONE is high for one cycle, then the state returns to IDLE.
- ABORT in FLUSH, CAPTURE or DRAIN:
  - The next state is IDLE.
  - Any pending strobe or ACK is cancelled.
  - FIFO contents and OVERRUN are kept.
  - ABORT has priority over all other events in the same cycle.
- Counters: unsigned CNT_W bits, no wrap-around within a frame.

## Timing
- All outputs are registered; no combinational paths from input to output.
- Reset values:
  - State = IDLE.
  - MODE = 0.
  - FIFO_RESET = 1. It drops at the first CLK edge after RESET is released.
  - All other outputs = 0.
- Asserting RESET during any state returns the block to the reset values immediately.
- FIFO_WRITE and FIFO_READ are always exactly one cycle wide, with at least one low cycle between pulses.
- Latencies:
  - ARM to first CAPTURE cycle: 1 + FLUSH_CYCLES cycles.
  - SAMPLE_VALID to FIFO_WRITE: 1 cycle.
  - HOST_REQ to HOST_ACK: 2 cycles.
  - Last HOST_ACK to FRAME_DONE: 1 cycle.
- Maximum throughput: one word every 3 cycles in DRAIN, one sample every 2 cycles in CAPTURE.

## Test plan
- Reset release, then ARM with MODE_REQ = 0, FRAME_LEN = 8, FLUSH_CYCLES = 4:
  - FIFO_RESET is high for 4 cycles.
  - 8 SAMPLE_VALID pulses every 2nd cycle give 8 FIFO_WRITE pulses.
  - 8 HOST_REQ pulses give 8 HOST_ACKs, each 2 cycles after its request.
  - FRAME_DONE pulses once; BUSY falls; OVERRUN = 0.
- Mode change: in IDLE with MODE = 0, set MODE_REQ = 1.
  - A single flush occurs and MODE = 1 after it.
  - No FIFO_ENABLE pulse; the block returns to IDLE.
- Back-to-back SAMPLE_VALID on consecutive cycles in CAPTURE:
  - Only the first produces FIFO_WRITE.
  - OVERRUN = 1 and stays high until the next ARM flush.
- FIFO_EMPTY = 1 during DRAIN with HOST_REQ pulses:
  - No FIFO_READ and no HOST_ACK.
  - Release FIFO_EMPTY; the next HOST_REQ is acknowledged in 2 cycles.
- ABORT in the same cycle as an accepted HOST_REQ in DRAIN:
  - No FIFO_READ and no HOST_ACK.
  - The block is in IDLE next cycle; BUSY = 0.
- RESET asserted mid-CAPTURE:
  - All outputs take their reset values immediately, with FIFO_RESET = 1.
  - After release, a new ARM gives a normal frame.
